mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_pkg.sv | 8 +
 rtl/mem_port_arbiter.sv | 64 ++++++
 tb/tb_mem_port_arbiter.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: state/tag encodings and datapath defaults shared by the
// VGA/CPU block-RAM port arbiter.
package mem_port_arbiter_pkg;
   localparam int ADDR_W_DEF = 10;
   localparam int DATA_W_DEF = 16;
   typedef enum logic [1:0] {IDLE, GNT_VGA, GNT_CPU} arb_state_t;
   typedef enum logic [1:0] {TAG_NONE, TAG_VGA, TAG_CPU} tag_t;
endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one block-RAM port between a VGA reader and a CPU,
// fixed VGA priority with no back-to-back grants to the same requester.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              vga_req,
   input  logic [ADDR_W-1:0] vga_addr,
   output logic              vga_ack,
   output logic              vga_rvalid,
   output logic [DATA_W-1:0] vga_rdata,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_ack,
   output logic              cpu_rvalid,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we,
   input  logic [DATA_W-1:0] mem_rdata
);
   arb_state_t state, state_nx;
   tag_t       tag;
   logic       vga_elig, cpu_elig;

   always_comb begin
      vga_elig = vga_req && state != GNT_VGA;
      cpu_elig = cpu_req && state != GNT_CPU;
      state_nx = vga_elig ? GNT_VGA : cpu_elig ? GNT_CPU : IDLE;
   end

   // tag follows the ack cycle by one, lining rvalid up with the RAM's output register
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         tag       <= TAG_NONE;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         state  <= state_nx;
         tag    <= state == GNT_VGA ? TAG_VGA : (state == GNT_CPU && !mem_we) ? TAG_CPU : TAG_NONE;
         mem_we <= state_nx == GNT_CPU && cpu_we;
         if (state_nx == GNT_VGA) mem_addr <= vga_addr;
         if (state_nx == GNT_CPU) begin
            mem_addr  <= cpu_addr;
            mem_wdata <= cpu_wdata;
         end
      end
   end

   assign vga_ack    = state == GNT_VGA;
   assign cpu_ack    = state == GNT_CPU;
   assign vga_rvalid = tag == TAG_VGA;
   assign cpu_rvalid = tag == TAG_CPU;
   assign vga_rdata  = mem_rdata;
   assign cpu_rdata  = mem_rdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and random checks of the arbiter against a
// transaction-level model with a shadow memory and expectation queues.
module tb_mem_port_arbiter;
   localparam int AW = 10;
   localparam int DW = 16;

   typedef struct {
      bit          cpu;
      bit          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
   } issue_t;

   logic          clk = 1'b0, reset = 1'b1;
   logic          vga_req = 1'b0, cpu_req = 1'b0, cpu_we = 1'b0;
   logic [AW-1:0] vga_addr = '0, cpu_addr = '0;
   logic [DW-1:0] cpu_wdata = '0;
   logic          vga_ack, vga_rvalid, cpu_ack, cpu_rvalid, mem_we;
   logic [DW-1:0] vga_rdata, cpu_rdata, mem_wdata, mem_rdata;
   logic [AW-1:0] mem_addr;

   int n_chk = 0, n_fail = 0;
   bit mon_en = 1'b0;

   logic [DW-1:0] ram    [1 << AW];
   logic [DW-1:0] shadow [1 << AW];

   // model state: who the model says is served this cycle (0 none, 1 vga, 2 cpu)
   int     g = 0, rv = 0;
   bit     g_we = 1'b0;
   issue_t iq[$];
   logic [DW-1:0] vq[$], cq[$];

   mem_port_arbiter dut (
      .clk(clk), .reset(reset),
      .vga_req(vga_req), .vga_addr(vga_addr), .vga_ack(vga_ack),
      .vga_rvalid(vga_rvalid), .vga_rdata(vga_rdata),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ack(cpu_ack), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] init_word(int i);
      return DW'(i * 37 + 16'h5A5A);
   endfunction

   initial
      for (int i = 0; i < (1 << AW); i++) begin
         ram[i]    = init_word(i);
         shadow[i] = init_word(i);
      end

   // block RAM with registered read-first output
   always @(posedge clk) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
   end

   task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // reference model: VGA wins unless it was served last cycle; the CPU likewise sits out after its own grant
   always @(posedge clk) begin
      int     g_new;
      issue_t e;
      if (reset) begin
         g = 0; rv = 0; g_we = 1'b0;
         iq.delete(); vq.delete(); cq.delete();
      end else begin
         rv = (g == 1) ? 1 : (g == 2 && !g_we) ? 2 : 0;
         g_new = (vga_req && g != 1) ? 1 : (cpu_req && g != 2) ? 2 : 0;
         if (g_new == 1) begin
            e = '{cpu: 1'b0, we: 1'b0, addr: vga_addr, wdata: '0};
            iq.push_back(e);
            vq.push_back(shadow[vga_addr]);
         end else if (g_new == 2) begin
            e = '{cpu: 1'b1, we: cpu_we, addr: cpu_addr, wdata: cpu_wdata};
            iq.push_back(e);
            if (cpu_we) shadow[cpu_addr] = cpu_wdata;
            else cq.push_back(shadow[cpu_addr]);
            g_we = cpu_we;
         end
         g = g_new;
      end
   end

   // monitor: compares every cycle, pops expectations whenever the DUT presents an ack or rvalid
   always @(negedge clk) begin
      issue_t e;
      if (mon_en) begin
         chk("vga_ack", vga_ack, g == 1);
         chk("cpu_ack", cpu_ack, g == 2);
         chk("vga_rvalid", vga_rvalid, rv == 1);
         chk("cpu_rvalid", cpu_rvalid, rv == 2);
         if (!cpu_ack) chk("mem_we_low", mem_we, 0);
         if (vga_ack || cpu_ack) begin
            chk("issue_pending", iq.size() != 0, 1);
            if (iq.size() != 0) begin
               e = iq.pop_front();
               chk("issue_owner", cpu_ack, e.cpu);
               chk("mem_addr", mem_addr, e.addr);
               chk("mem_we", mem_we, e.we);
               if (e.we) chk("mem_wdata", mem_wdata, e.wdata);
            end
         end
         if (vga_rvalid) begin
            chk("vga_read_pending", vq.size() != 0, 1);
            if (vq.size() != 0) chk("vga_rdata", vga_rdata, vq.pop_front());
         end
         if (cpu_rvalid) begin
            chk("cpu_read_pending", cq.size() != 0, 1);
            if (cq.size() != 0) chk("cpu_rdata", cpu_rdata, cq.pop_front());
         end
      end
   end

   task automatic vga_driver(int n);
      for (int k = 0; k < n; k++) begin
         int w;
         vga_req = 1'b0;
         repeat ($urandom_range(0, 3)) @(negedge clk);
         vga_req  = 1'b1;
         vga_addr = AW'($urandom_range(0, 15));
         w = 0;
         do begin
            @(negedge clk);
            w++;
         end while (!vga_ack && w < 8);
         if (!vga_ack) chk("vga_ack_timeout", 0, 1);
      end
      vga_req = 1'b0;
   endtask

   task automatic cpu_driver(int n);
      for (int k = 0; k < n; k++) begin
         int w;
         cpu_req = 1'b0;
         repeat ($urandom_range(0, 3)) @(negedge clk);
         cpu_req   = 1'b1;
         cpu_we    = 1'($urandom_range(0, 1));
         cpu_addr  = AW'($urandom_range(0, 15));
         cpu_wdata = DW'($urandom);
         w = 0;
         do begin
            @(negedge clk);
            w++;
         end while (!cpu_ack && w < 8);
         if (!cpu_ack) chk("cpu_ack_timeout", 0, 1);
      end
      cpu_req = 1'b0;
   endtask

   initial begin
      int pulses;
      bit we_seen;
      repeat (3) @(negedge clk);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_acks", {vga_ack, cpu_ack, vga_rvalid, cpu_rvalid}, 0);
      mon_en = 1'b1;
      reset  = 1'b0;

      vga_req = 1'b1; vga_addr = 10'h012;
      @(negedge clk);
      chk("d_vga_ack", vga_ack, 1);
      chk("d_vga_addr", mem_addr, 10'h012);
      vga_req = 1'b0;
      @(negedge clk);
      chk("d_vga_rvalid", vga_rvalid, 1);
      chk("d_vga_rdata", vga_rdata, init_word(10'h012));

      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 10'h100; cpu_wdata = 16'hBEEF;
      @(negedge clk);
      chk("d_wr_ack", cpu_ack, 1);
      chk("d_wr_we", mem_we, 1);
      cpu_req = 1'b0;
      @(negedge clk);
      chk("d_wr_we_drop", mem_we, 0);
      chk("d_wr_no_rvalid", cpu_rvalid, 0);
      cpu_req = 1'b1; cpu_we = 1'b0;
      @(negedge clk);
      chk("d_rd_ack", cpu_ack, 1);
      cpu_req = 1'b0;
      @(negedge clk);
      chk("d_rd_rvalid", cpu_rvalid, 1);
      chk("d_rd_beef", cpu_rdata, 16'hBEEF);

      vga_req = 1'b1; vga_addr = 10'h020; cpu_req = 1'b1; cpu_addr = 10'h030;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("d_alt_vga", vga_ack, i % 2 == 0);
         chk("d_alt_cpu", cpu_ack, i % 2 == 1);
      end
      vga_req = 1'b0; cpu_req = 1'b0;
      @(negedge clk);

      vga_req = 1'b1; vga_addr = 10'h040;
      pulses = 0; we_seen = 1'b0;
      repeat (6) begin
         @(negedge clk);
         pulses += int'(vga_ack);
         we_seen |= mem_we;
      end
      vga_req = 1'b0;
      chk("d_vga_only_pulses", pulses, 3);
      chk("d_vga_only_we", we_seen, 0);
      repeat (2) @(negedge clk);

      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h100;
      @(negedge clk);
      chk("d_rst_rd_ack", cpu_ack, 1);
      cpu_req = 1'b0; reset = 1'b1;
      @(negedge clk);
      chk("d_rst_no_rvalid", cpu_rvalid, 0);
      chk("d_rst_outs", {vga_ack, cpu_ack, vga_rvalid, mem_we}, 0);
      chk("d_rst_addr", mem_addr, 0);
      chk("d_rst_wdata", mem_wdata, 0);
      reset = 1'b0;
      @(negedge clk);

      fork
         vga_driver(60);
         cpu_driver(60);
      join
      repeat (4) @(negedge clk);
      chk("end_issue_q", iq.size(), 0);
      chk("end_vga_q", vq.size(), 0);
      chk("end_cpu_q", cq.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end
endmodule
